// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit in front of the word-wide data memory, with read-modify-write for SB/SH.
// Optional macro MEM_MISALIGN_TRAP_EN enables the misaligned-address traps (EXC_ADEL/EXC_ADES). Rev 1.0
`default_nettype none
`timescale 1ns/1ps

`ifndef TRAP_STALL
`define TRAP_STALL 8'h00
`endif

module mem_access #(
  parameter logic [7:0] EXC_ADEL = 8'h04,
  parameter logic [7:0] EXC_ADES = 8'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [11:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [7:0]  in_exception,
  output logic [11:0] dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_we,
  input  logic [31:0] dm_dout,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic [7:0]  out_exception
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RMW_WR, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  code_q, code_d;
  logic        kill_q, kill_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  exc_q, exc_d;

  logic        in_is_load, in_is_store, in_misaligned;
  logic [7:0]  in_code;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign in_is_load  = (in_op >= OP_LW) && (in_op <= OP_LBU);
  assign in_is_store = (in_op >= OP_SW) && (in_op <= OP_SB);

`ifdef MEM_MISALIGN_TRAP_EN
  assign in_misaligned = (((in_op == OP_LW) || (in_op == OP_SW)) && (in_addr[1:0] != 2'b00)) ||
                         (((in_op == OP_LH) || (in_op == OP_LHU) || (in_op == OP_SH)) && in_addr[0]);
`else
  assign in_misaligned = 1'b0;
`endif

  // Upstream exceptions win over a locally detected misalignment.
  assign in_code = (in_exception != 8'h00) ? in_exception :
                   in_misaligned ? (in_is_load ? EXC_ADEL : EXC_ADES) : 8'h00;

  assign half_sel = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];

  always_comb begin
    byte_sel = dm_dout[7:0];
    case (addr_q[1:0])
      2'd1:    byte_sel = dm_dout[15:8];
      2'd2:    byte_sel = dm_dout[23:16];
      2'd3:    byte_sel = dm_dout[31:24];
      default: byte_sel = dm_dout[7:0];
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    code_d    = code_q;
    kill_d    = kill_q;
    merge_d   = merge_q;
    rdata_d   = rdata_q;
    exc_d     = exc_q;
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    dm_addr   = 12'h000;
    dm_din    = 32'h0000_0000;
    dm_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          addr_d  = in_addr;
          wdata_d = in_wdata;
          code_d  = in_code;
          kill_d  = (in_code != 8'h00) || !(in_is_load || in_is_store);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Killed requests idle through this cycle so every non-RMW completion has the same latency.
        state_d = S_DONE;
        rdata_d = 32'h0000_0000;
        exc_d   = code_q;
        if (!kill_q) begin
          dm_addr = addr_q;
          case (op_q)
            OP_LW:  rdata_d = dm_dout;
            OP_LH:  rdata_d = {{16{half_sel[15]}}, half_sel};
            OP_LHU: rdata_d = {16'h0000, half_sel};
            OP_LB:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: rdata_d = {24'h000000, byte_sel};
            OP_SW: begin
              dm_we  = 1'b1;
              dm_din = wdata_q;
            end
            OP_SH: begin
              merge_d = addr_q[1] ? {wdata_q[15:0], dm_dout[15:0]}
                                  : {dm_dout[31:16], wdata_q[15:0]};
              state_d = S_RMW_WR;
            end
            OP_SB: begin
              case (addr_q[1:0])
                2'd1:    merge_d = {dm_dout[31:16], wdata_q[7:0], dm_dout[7:0]};
                2'd2:    merge_d = {dm_dout[31:24], wdata_q[7:0], dm_dout[15:0]};
                2'd3:    merge_d = {wdata_q[7:0], dm_dout[23:0]};
                default: merge_d = {dm_dout[31:8], wdata_q[7:0]};
              endcase
              state_d = S_RMW_WR;
            end
            default: rdata_d = 32'h0000_0000;
          endcase
        end
      end
      S_RMW_WR: begin
        dm_addr = addr_q;
        dm_din  = merge_q;
        dm_we   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      addr_q  <= 12'h000;
      wdata_q <= 32'h0000_0000;
      code_q  <= 8'h00;
      kill_q  <= 1'b0;
      merge_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      exc_q   <= `TRAP_STALL;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      code_q  <= code_d;
      kill_q  <= kill_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  assign out_rdata     = rdata_q;
  assign out_exception = exc_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// tb_mem_access: random and directed stimulus for mem_access, checked against a transaction-level model.
`default_nettype none
`timescale 1ns/1ps

`ifndef TRAP_STALL
`define TRAP_STALL 8'h00
`endif

module tb_mem_access;
  localparam logic [3:0] OP_NONE = 4'd0, OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [11:0] in_addr = 12'h000;
  logic [31:0] in_wdata = 32'h0;
  logic [7:0]  in_exception = 8'h00;
  logic [11:0] dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic [7:0]  out_exception;

  mem_access dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_exception(in_exception),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout),
    .out_valid(out_valid), .out_rdata(out_rdata), .out_exception(out_exception)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT, and the model's idea of what it should hold.
  logic [31:0] env_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  assign dm_dout = env_mem[dm_addr[11:2]];
  always @(posedge clk) if (dm_we) env_mem[dm_addr[11:2]] <= dm_din;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [31:0] rdata; logic [7:0] exc; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, last_due = -1, we_cnt = 0, we_exp = 0;
  bit chk_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion and handshake checks on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (dm_we === 1'b1) we_cnt++;
      check32("in_ready", {31'b0, in_ready}, {31'b0, (cyc > last_due)});
      if (q.size() > 0 && q[0].due == cyc) begin
        check32("out_valid", {31'b0, out_valid}, 32'd1);
        check32("out_rdata", out_rdata, q[0].rdata);
        check32("out_exception", {24'b0, out_exception}, {24'b0, q[0].exc});
        void'(q.pop_front());
      end else begin
        check32("out_valid_quiet", {31'b0, out_valid}, 32'd0);
      end
    end
  end

  // Transaction-level model: result, latency and memory effect of one accepted request.
  function automatic void model(input logic [3:0] op, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic [7:0] exc, input int k);
    bit load, store, mis, kill;
    logic [7:0] code;
    logic [31:0] w, rd, h, b;
    int hs, bs, widx;
    exp_t e;
    load  = (op >= 1) && (op <= 5);
    store = (op >= 6) && (op <= 8);
    mis   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((op == OP_LW || op == OP_SW) && (addr % 4 != 0)) mis = 1'b1;
    if ((op == OP_LH || op == OP_LHU || op == OP_SH) && (addr % 2 != 0)) mis = 1'b1;
`endif
    code = (exc != 0) ? exc : (mis ? (load ? 8'h04 : 8'h05) : 8'h00);
    kill = (code != 0) || !(load || store);
    widx = int'(addr) / 4;
    w  = ref_mem[widx];
    hs = 16 * ((int'(addr) / 2) % 2);
    bs = 8 * (int'(addr) % 4);
    h  = (w >> hs) & 32'h0000FFFF;
    b  = (w >> bs) & 32'h000000FF;
    rd = 32'h0;
    if (!kill) begin
      case (op)
        OP_LW:  rd = w;
        OP_LH:  rd = h[15] ? (h | 32'hFFFF0000) : h;
        OP_LHU: rd = h;
        OP_LB:  rd = b[7] ? (b | 32'hFFFFFF00) : b;
        OP_LBU: rd = b;
        OP_SW: begin ref_mem[widx] = wdata; we_exp++; end
        OP_SH: begin
          ref_mem[widx] = (w & ~(32'h0000FFFF << hs)) | ((wdata & 32'h0000FFFF) << hs);
          we_exp++;
        end
        OP_SB: begin
          ref_mem[widx] = (w & ~(32'h000000FF << bs)) | ((wdata & 32'h000000FF) << bs);
          we_exp++;
        end
        default: rd = 32'h0;
      endcase
    end
    e.due   = k + ((!kill && (op == OP_SH || op == OP_SB)) ? 2 : 1);
    e.rdata = rd;
    e.exc   = code;
    q.push_back(e);
    last_due = e.due;
  endfunction

  task automatic do_req(input logic [3:0] op, input logic [11:0] addr,
                        input logic [31:0] wdata, input logic [7:0] exc);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata; in_exception = exc;
    while (!in_ready && waited <= 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 within 20 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = 4'($urandom); in_addr = 12'($urandom); in_wdata = $urandom; in_exception = 8'($urandom);
    model(op, addr, wdata, exc, cyc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d completions outstanding expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int bad;
    logic [3:0] rop;
    logic [7:0] rexc;
    for (int i = 0; i < 1024; i++) begin env_mem[i] = 32'h0; ref_mem[i] = 32'h0; end

    repeat (3) @(negedge clk);
    check32("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check32("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check32("reset_out_rdata", out_rdata, 32'h0);
    check32("reset_out_exception", {24'b0, out_exception}, {24'b0, `TRAP_STALL});
    check32("reset_dm_we", {31'b0, dm_we}, 32'd0);
    check32("reset_dm_addr", {20'b0, dm_addr}, 32'h0);
    check32("reset_dm_din", dm_din, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1 chk_en = 1'b1;

    do_req(OP_SW, 12'h010, 32'hDEADBEEF, 8'h00);
    do_req(OP_LW, 12'h010, 32'h0, 8'h00);
    drain();
    check32("lw_010", out_rdata, 32'hDEADBEEF);
    check32("lw_010_exc", {24'b0, out_exception}, 32'h0);

    do_req(OP_SW, 12'h020, 32'h11223344, 8'h00);
    do_req(OP_SB, 12'h022, 32'hFFFFFFAA, 8'h00);
    drain();
    check32("sb_022_word", env_mem[8], 32'h11AA3344);
    do_req(OP_LB, 12'h022, 32'h0, 8'h00);
    drain();
    check32("lb_022", out_rdata, 32'hFFFFFFAA);
    do_req(OP_LBU, 12'h022, 32'h0, 8'h00);
    drain();
    check32("lbu_022", out_rdata, 32'h000000AA);

    do_req(OP_SW, 12'h030, 32'h0, 8'h00);
    do_req(OP_SH, 12'h032, 32'h00008001, 8'h00);
    do_req(OP_LH, 12'h032, 32'h0, 8'h00);
    drain();
    check32("lh_032", out_rdata, 32'hFFFF8001);
    do_req(OP_LHU, 12'h032, 32'h0, 8'h00);
    drain();
    check32("lhu_032", out_rdata, 32'h00008001);

    do_req(OP_LW, 12'h013, 32'h0, 8'h00);
    drain();
`ifdef MEM_MISALIGN_TRAP_EN
    check32("lw_013_exc", {24'b0, out_exception}, 32'h04);
    do_req(OP_SH, 12'h031, 32'h0000BEEF, 8'h00);
    drain();
    check32("sh_031_exc", {24'b0, out_exception}, 32'h05);
    check32("sh_031_word", env_mem[12], 32'h80010000);
`else
    check32("lw_013_word", out_rdata, 32'hDEADBEEF);
`endif

    do_req(OP_SW, 12'h040, 32'h55AA55AA, 8'h0A);
    drain();
    check32("sw_exc_code", {24'b0, out_exception}, 32'h0A);
    check32("sw_exc_word", env_mem[16], 32'h0);

    // Reset landing in the RMW write cycle must abandon the write.
    do_req(OP_SW, 12'h050, 32'h12345678, 8'h00);
    drain();
    chk_en = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_SB; in_addr = 12'h051; in_wdata = 32'h00000099; in_exception = 8'h00;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check32("rmw_we_before_reset", {31'b0, dm_we}, 32'd1);
    rst = 1'b0;
    #1;
    check32("rmw_reset_dm_we", {31'b0, dm_we}, 32'd0);
    check32("rmw_reset_in_ready", {31'b0, in_ready}, 32'd1);
    check32("rmw_reset_out_exception", {24'b0, out_exception}, {24'b0, `TRAP_STALL});
    check32("rmw_reset_out_rdata", out_rdata, 32'h0);
    @(posedge clk); #1;
    check32("rmw_reset_word", env_mem[20], 32'h12345678);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 chk_en = 1'b1;

    for (int n = 0; n < 300; n++) begin
      rop  = 4'($urandom_range(0, 15));
      rexc = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      do_req(rop, 12'($urandom_range(0, 255)), $urandom, rexc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    check32("dm_we_cycles", we_cnt, we_exp);
    bad = 0;
    for (int i = 0; i < 128; i++) if (env_mem[i] !== ref_mem[i]) bad++;
    check32("memory_image_mismatch_words", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
